sha_256_padder: RTL
===================

Name: sha_256_padder

Overview:
- Upstream feeder for the sha_256 core.
- Accepts an arbitrary-length message as a byte stream with valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Emits 512-bit blocks through a valid/ready handshake, each block formatted exactly as the core's i_msg expects (first byte in i_msg[511:504]).

Parameters:
MSG_SIZ, 512, block width in bits
DATA_W, 8, input byte width (fixed at 8; not to be overridden)
LEN_W, 64, message bit-length counter width

Ports:
usr_clk  input  1  system clock
usr_reset_n  input  1  async active-low reset
i_valid  input  1  input byte valid
i_data  input  DATA_W  message byte
i_last  input  1  final byte of message; qualified by i_valid
o_ready  output  1  padder can accept a byte
o_blk_valid  output  1  o_blk holds a complete block
o_blk  output  MSG_SIZ  padded block, MSB-first byte order
o_blk_last  output  1  block is the final block of the message
i_blk_ready  input  1  downstream consumes block

Behaviour:
- One clock (usr_clk). Reset is asynchronous and active-low (usr_reset_n). Reset clears every register.
- Reset values: o_ready=0, o_blk_valid=0, o_blk=0, o_blk_last=0. State=FILL, byte counter cnt(6b)=0, bit length len=0, pend_pad=0, pend_len=0. o_ready rises 1 cycle after reset release.
- Byte k of the current block is written at o_blk[MSG_SIZ-1-8k -: 8]. The buffer is zeroed whenever a block handshakes, so zero fill needs no explicit writes.
- len increments by 8 per accepted byte and wraps modulo 2^LEN_W.
- FILL state:
  - o_ready=1; a byte is accepted on i_valid&o_ready.
  - Non-last byte at cnt==63 -> EMIT, last=0.
  - i_last with cnt<63 -> PAD.
  - i_last at cnt==63 -> EMIT with pend_pad=1.
- PAD state (o_ready=0):
  - Write 0x80 at cnt, then cnt++.
  - New cnt<=56 -> LEN.
  - Otherwise -> EMIT (last=0) with pend_len=1.
- LEN state (o_ready=0): write len into o_blk[63:0], -> EMIT with o_blk_last=1.
- EMIT state:
  - o_blk_valid=1, o_ready=0.
  - o_blk and o_blk_last are held stable until i_blk_ready.
  - On handshake: clear buffer, cnt=0, o_blk_valid=0 the next cycle.
  - Next state: pend_pad -> PAD; else pend_len -> LEN; else FILL. On return to FILL after a last block, len=0.
- Latency: o_blk_valid rises 2 edges after the edge that accepts a last byte (PAD, LEN), when padding fits in the same block.
- Throughput: 1 byte/cycle in FILL. A block occupies EMIT for at least 1 cycle.
- i_last without i_valid is ignored. Zero-length messages are not supported.
- i_valid while o_ready=0: the byte is not consumed, and the source must hold it.
- Reset mid-message aborts the message. No partial block is emitted.

Optional Feature:
- Macro: SHA_PAD_BLKCNT_EN.
- Defined:
  - Adds output o_blk_cnt [15:0]: count of blocks emitted for the current message, including the current one.
  - Value 1 on the first block. Resets to 0 after the last-block handshake and on reset. Saturates at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sha_pkg holds:
  - state encoding (FILL, PAD, LEN, EMIT)
  - SHA_PAD_BYTE = 8'h80
  - LEN_FIELD_LSB = 0, LEN_FIELD_W = 64
  - MAX_FILL_IDX = 55
- The same package is shared with sha_256 for block width constants.
- No sub-module: the buffer write logic and FSM stay in one module.

Test Plan:
- "abc" (61,62,63, last) with i_blk_ready=1:
  - One block with o_blk_last=1.
  - o_blk = 512'h61626380_0..0_00000018.
  - o_blk_valid rises 2 edges after the 'c' is accepted.
- 55-byte message of 0x00: one block, byte55=0x80, o_blk[63:0]=64'h1B8, o_blk_last=1.
- 56-byte message: two blocks.
  - First: byte56=0x80, rest zero, o_blk_last=0.
  - Second: all zero except [63:0]=64'h1C0, o_blk_last=1.
- 64-byte message: two blocks.
  - First: data only.
  - Second: byte0=0x80, [63:0]=64'h200, o_blk_last=1 (pend_pad path).
- Backpressure: hold i_blk_ready=0 for 5 cycles in EMIT. o_blk and o_blk_last stay unchanged, o_ready=0, and no input bytes are lost.
- Reset asserted after 20 bytes: outputs go to 0 immediately. A following "abc" message produces the identical "abc" block with length 0x18.

Source files
------------

// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Constants and types shared by the SHA-256 block path (padder and core).
//   SHA_BLK_W      : message block width in bits
//   pad_state_e    : padder FSM encoding (FILL, PAD, LEN, EMIT)
//   SHA_PAD_BYTE   : first padding byte (single 1 bit followed by zeros)
//   LEN_FIELD_*    : position of the 64-bit message length inside a block
//   MAX_FILL_IDX   : highest byte index that can take the 0x80 marker and
//                    still leave room for the length field in that block
// -----------------------------------------------------------------------------
package sha_pkg;

    localparam int SHA_BLK_W = 512;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        LEN  = 2'd2,
        EMIT = 2'd3
    } pad_state_e;

    localparam logic [7:0] SHA_PAD_BYTE  = 8'h80;
    localparam int         LEN_FIELD_LSB = 0;
    localparam int         LEN_FIELD_W   = 64;
    localparam int         MAX_FILL_IDX  = 55;

endpackage

// File: rtl/sha_256_padder.sv
// -----------------------------------------------------------------------------
// sha_256_padder
// Byte-stream front end for the sha_256 core. Collects message bytes into a
// 512-bit block (first byte in the top byte lane), appends the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, and hands out complete
// blocks over a valid/ready handshake.
//
// Ports:
//   usr_clk, usr_reset_n : clock, asynchronous active-low reset
//   i_valid/i_data/i_last: input byte stream; i_last marks the final byte
//   o_ready              : padder accepts a byte this cycle
//   o_blk_valid/o_blk    : padded block available, held until i_blk_ready
//   o_blk_last           : block is the final one of the message
//   i_blk_ready          : downstream takes the block
//   o_blk_cnt            : (only with SHA_PAD_BLKCNT_EN) blocks emitted for
//                          the current message, saturating at 0xFFFF
//
// Build option: define SHA_PAD_BLKCNT_EN to add the o_blk_cnt output.
// DATA_W is a byte and is not meant to be overridden.
// -----------------------------------------------------------------------------
module sha_256_padder
    import sha_pkg::*;
#(
    parameter int MSG_SIZ = SHA_BLK_W,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 64
) (
    input  logic               usr_clk,
    input  logic               usr_reset_n,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_last,
    input  logic               i_blk_ready,
    output logic               o_ready,
    output logic               o_blk_valid,
    output logic [MSG_SIZ-1:0] o_blk,
    output logic               o_blk_last
`ifdef SHA_PAD_BLKCNT_EN
    ,
    output logic [15:0]        o_blk_cnt
`endif
);

    localparam int                BYTES    = MSG_SIZ / DATA_W;
    localparam int                CNT_W    = $clog2(BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(MAX_FILL_IDX);

    pad_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               pend_pad_q, pend_pad_d;
    logic               pend_len_q, pend_len_d;
    logic [MSG_SIZ-1:0] blk_q, blk_d;
    logic               last_q, last_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_byte;

    // o_ready is registered so it stays low for the first cycle after reset.
    assign accept = i_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        pend_pad_d = pend_pad_q;
        pend_len_d = pend_len_q;
        blk_d      = blk_q;
        last_d     = last_q;
        wr_en      = 1'b0;
        wr_byte    = '0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_byte = i_data;
                    cnt_d   = cnt_q + 1'b1;
                    len_d   = len_q + LEN_W'(DATA_W);
                    if (i_last) begin
                        if (cnt_q == LAST_IDX) begin
                            // Block is full: marker goes into a fresh block.
                            state_d    = EMIT;
                            pend_pad_d = 1'b1;
                        end else begin
                            state_d = PAD;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = EMIT;
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_byte = SHA_PAD_BYTE;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q <= FILL_MAX) begin
                    state_d = LEN;
                end else begin
                    // No room left for the length: it goes in the next block.
                    state_d    = EMIT;
                    pend_len_d = 1'b1;
                end
            end
            LEN: begin
                blk_d[LEN_FIELD_LSB +: LEN_FIELD_W] = LEN_FIELD_W'(len_q);
                last_d  = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (i_blk_ready) begin
                    // Zeroing here provides the zero fill of the next block.
                    blk_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        len_d = '0;
                    end
                    if (pend_pad_q) begin
                        state_d    = PAD;
                        pend_pad_d = 1'b0;
                    end else if (pend_len_q) begin
                        state_d    = LEN;
                        pend_len_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Byte lane k of the block sits at bits [MSG_SIZ-1-8k -: 8].
        for (int k = 0; k < BYTES; k++) begin
            if (wr_en && (cnt_q == CNT_W'(k))) begin
                blk_d[MSG_SIZ-1-DATA_W*k -: DATA_W] = wr_byte;
            end
        end
    end

    assign ready_d = (state_d == FILL);
    assign valid_d = (state_d == EMIT);

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            len_q      <= '0;
            pend_pad_q <= 1'b0;
            pend_len_q <= 1'b0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pend_pad_q <= pend_pad_d;
            pend_len_q <= pend_len_d;
            blk_q      <= blk_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_blk_valid = valid_q;
    assign o_blk       = blk_q;
    assign o_blk_last  = last_q;

`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    // Counts up on each entry into EMIT; cleared once the final block leaves.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (state_q == EMIT && i_blk_ready && last_q) begin
            blk_cnt_d = '0;
        end else if (state_d == EMIT && state_q != EMIT && blk_cnt_q != 16'hFFFF) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign o_blk_cnt = blk_cnt_q;
`endif

endmodule
